k7_aurora_link_ctrl: RTL and testbench
======================================

Name: k7_aurora_link_ctrl

Overview:
Bring-up and recovery sequencer for one Kintex-7 Aurora 64b66b lane.
- Drives the core's PMA_INIT and RESET_PB in the required order after the clock manager locks.
- Waits for CHANNEL_UP with a timeout and retries a bounded number of times.
- Monitors a live link and re-runs the reset sequence on hard error or a sustained channel drop.
- Sits between the clocking block and the Aurora core; reports link status to the host-side logic.

Parameters:
PMA_CYCLES, 100, CLK50 cycles PMA_INIT is held high before release (>=1)
PB_CYCLES, 100, CLK50 cycles RESET_PB is held high after PMA_INIT release (>=1)
UP_TIMEOUT, 1000000, CLK50 cycles to wait for CHANNEL_UP after RESET_PB release (>=1)
DOWN_FILTER, 16, consecutive synced CHANNEL_UP=0 cycles in UP that trigger recovery (>=1)
MAX_RETRY, 7, failed attempts allowed before declaring FAIL (0..255)
TMR_W, 24, phase timer width; every cycle parameter must be < 2^TMR_W

Ports:
CLK50  in  1  system clock; all logic in this domain
RST  in  1  synchronous, active-high reset
DCM_LOCKED  in  1  clock manager lock, CLK50-synchronous
CHANNEL_UP  in  1  Aurora channel up, asynchronous (user clock domain)
HARD_ERR  in  1  Aurora hard error, asynchronous (user clock domain)
RETRY_REQ  in  1  single-cycle manual relink request
PMA_INIT  out  1  to Aurora pma_init
RESET_PB  out  1  to Aurora reset_pb
LINK_UP  out  1  link usable
LINK_FAIL  out  1  retries exhausted
RETRY_CNT  out  8  failed attempts since last successful link-up
LINK_DROPS  out  8  saturating count of UP->recovery events
STATE  out  3  current state code, for debug

Behaviour:
- Reset values: PMA_INIT=1, RESET_PB=1, LINK_UP=0, LINK_FAIL=0, RETRY_CNT=0, LINK_DROPS=0, STATE=WAIT_LOCK. Synchronizers and all counters also reset to 0.
- All outputs are registered and change on the same edge as the state transition.
- Synchronizers: CHANNEL_UP and HARD_ERR each pass through a 2-flop synchronizer (up_s, err_s), giving 2 cycles of latency.
- State codes: WAIT_LOCK=0, PMA_RST=1, PB_RST=2, WAIT_UP=3, UP=4, FAIL=5.
- Output levels by state:
  - PMA_INIT=1 in WAIT_LOCK, PMA_RST and FAIL.
  - RESET_PB=1 in WAIT_LOCK, PMA_RST, PB_RST and FAIL.
  - LINK_UP=1 only in UP.
  - LINK_FAIL=1 only in FAIL.
- Priority each cycle: RST > DCM_LOCKED=0 (any state -> WAIT_LOCK; RETRY_CNT kept) > RETRY_REQ > the normal transitions below.
- RETRY_REQ:
  - In any state except WAIT_LOCK: go to PMA_RST, clear RETRY_CNT, clear the timer.
  - Ignored in WAIT_LOCK.
- WAIT_LOCK: when DCM_LOCKED=1, go to PMA_RST; timer=0.
- PMA_RST: timer increments; at timer==PMA_CYCLES-1, go to PB_RST and clear the timer. PMA_INIT is high for exactly PMA_CYCLES cycles.
- PB_RST: at timer==PB_CYCLES-1, go to WAIT_UP and clear the timer.
- WAIT_UP:
  - If up_s=1: go to UP and clear RETRY_CNT.
  - Else if timer==UP_TIMEOUT-1:
    - If RETRY_CNT==MAX_RETRY: go to FAIL.
    - Else: RETRY_CNT+1, go to PMA_RST.
  - If up_s=1 on the timeout cycle, UP wins.
- UP:
  - Down counter increments while up_s=0 and clears when up_s=1.
  - Recovery triggers on err_s=1 (immediate) or when the down counter reaches DOWN_FILTER.
  - On recovery: go to PMA_RST, LINK_DROPS+1 (saturating at 255), RETRY_CNT+1, down counter cleared.
- FAIL: hold until RETRY_REQ (see above) or loss of lock.
- Counter rules:
  - RETRY_CNT saturates at 255.
  - The timer is cleared on every state entry.
  - No counter wraps.

Decomposition:
- Package aurora_ctrl_pkg: state code constants (3-bit) and the default TMR_W.
- Sub-module aurora_sync2: 2-flop bit synchronizer with synchronous active-high reset; instantiated twice.

Test Plan:
All cases use params PMA_CYCLES=4, PB_CYCLES=3, UP_TIMEOUT=20, DOWN_FILTER=4, MAX_RETRY=2.
1. Nominal bring-up. RST then DCM_LOCKED=1 at cycle 10; CHANNEL_UP=1 from cycle 25 -> PMA_INIT falls after 4 cycles in PMA_RST, RESET_PB falls 3 cycles later; LINK_UP=1 two to three cycles after CHANNEL_UP; RETRY_CNT=0.
2. Timeout and fail. CHANNEL_UP held 0 -> three WAIT_UP timeouts of 20 cycles each; RETRY_CNT counts 1, 2; then FAIL with LINK_FAIL=1, PMA_INIT=1, RESET_PB=1, STATE=5. A RETRY_REQ pulse then gives PMA_RST, LINK_FAIL=0, RETRY_CNT=0.
3. Down filter. In UP, drop CHANNEL_UP for 3 cycles -> LINK_UP stays 1. Drop it for 5 cycles -> recovery with LINK_DROPS=1, LINK_UP=0 and PMA_INIT=1 on the same edge.
4. Hard error. In UP, a 1-cycle HARD_ERR pulse -> recovery 3 cycles later (2 sync + 1); LINK_DROPS increments.
5. Lock loss. DCM_LOCKED=0 mid-PB_RST -> WAIT_LOCK next edge, both resets high, RETRY_CNT unchanged. Relock resumes at PMA_RST.
6. Simultaneous events. CHANNEL_UP synced high exactly on the timeout cycle -> UP, no retry. RETRY_REQ in the same cycle as DCM_LOCKED=0 -> WAIT_LOCK.

Source files
------------

// File: rtl/aurora_ctrl_pkg.sv
// Shared state codes and defaults for the Aurora lane bring-up sequencer.
package aurora_ctrl_pkg;

  localparam int TMR_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PMA_RST   = 3'd1,
    ST_PB_RST    = 3'd2,
    ST_WAIT_UP   = 3'd3,
    ST_UP        = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/aurora_sync2.sv
// Two-flop single-bit synchronizer, synchronous active-high reset.
module aurora_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the async level, then re-register to settle metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/k7_aurora_link_ctrl.sv
// Bring-up / recovery sequencer for one Kintex-7 Aurora 64b66b lane.
// Sequences pma_init then reset_pb, waits for channel-up with retries,
// and re-runs the sequence on hard error or a filtered channel drop.
module k7_aurora_link_ctrl
  import aurora_ctrl_pkg::*;
#(
  parameter int PMA_CYCLES  = 100,
  parameter int PB_CYCLES   = 100,
  parameter int UP_TIMEOUT  = 1000000,
  parameter int DOWN_FILTER = 16,
  parameter int MAX_RETRY   = 7,
  parameter int TMR_W       = TMR_W_DEF
) (
  input  logic       CLK50,
  input  logic       RST,
  input  logic       DCM_LOCKED,
  input  logic       CHANNEL_UP,
  input  logic       HARD_ERR,
  input  logic       RETRY_REQ,
  output logic       PMA_INIT,
  output logic       RESET_PB,
  output logic       LINK_UP,
  output logic       LINK_FAIL,
  output logic [7:0] RETRY_CNT,
  output logic [7:0] LINK_DROPS,
  output logic [2:0] STATE
);

  localparam logic [TMR_W-1:0] PMA_LAST = TMR_W'(PMA_CYCLES - 1);
  localparam logic [TMR_W-1:0] PB_LAST  = TMR_W'(PB_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(UP_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DF_LAST  = TMR_W'(DOWN_FILTER - 1);
  localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRY);

  logic up_s, err_s;

  aurora_sync2 u_sync_up (
    .clk_i (CLK50),
    .rst_i (RST),
    .d_i   (CHANNEL_UP),
    .q_o   (up_s)
  );

  aurora_sync2 u_sync_err (
    .clk_i (CLK50),
    .rst_i (RST),
    .d_i   (HARD_ERR),
    .q_o   (err_s)
  );

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic [7:0]       drops_q, drops_d;
  logic             pma_q, pb_q, up_q, fail_q;

  // Next-state / counter logic; timer and down counter default to 0 so
  // every state entry starts with a cleared timer.
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    dcnt_d  = '0;
    rcnt_d  = rcnt_q;
    drops_d = drops_q;
    if (!DCM_LOCKED) begin
      state_d = ST_WAIT_LOCK;
    end else if (RETRY_REQ && (state_q != ST_WAIT_LOCK)) begin
      state_d = ST_PMA_RST;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: state_d = ST_PMA_RST;
        ST_PMA_RST: begin
          if (tmr_q == PMA_LAST) state_d = ST_PB_RST;
          else                   tmr_d   = tmr_q + 1'b1;
        end
        ST_PB_RST: begin
          if (tmr_q == PB_LAST) state_d = ST_WAIT_UP;
          else                  tmr_d   = tmr_q + 1'b1;
        end
        ST_WAIT_UP: begin
          if (up_s) begin
            state_d = ST_UP;
            rcnt_d  = '0;
          end else if (tmr_q == TO_LAST) begin
            // >= so a count already past the limit (after an UP recovery
            // with a small limit) still ends in FAIL rather than looping.
            if (rcnt_q >= RETRY_LIM) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PMA_RST;
              rcnt_d  = sat_inc8(rcnt_q);
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_UP: begin
          if (err_s || (!up_s && (dcnt_q == DF_LAST))) begin
            state_d = ST_PMA_RST;
            drops_d = sat_inc8(drops_q);
            rcnt_d  = sat_inc8(rcnt_q);
          end else if (!up_s) begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // State, counters, and outputs decoded from the next state so the
  // outputs move on the same edge as the transition.
  always_ff @(posedge CLK50) begin
    if (RST) begin
      state_q <= ST_WAIT_LOCK;
      tmr_q   <= '0;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      drops_q <= '0;
      pma_q   <= 1'b1;
      pb_q    <= 1'b1;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      drops_q <= drops_d;
      pma_q   <= (state_d == ST_WAIT_LOCK) || (state_d == ST_PMA_RST) ||
                 (state_d == ST_FAIL);
      pb_q    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_PMA_RST) ||
                 (state_d == ST_PB_RST)    || (state_d == ST_FAIL);
      up_q    <= (state_d == ST_UP);
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign PMA_INIT   = pma_q;
  assign RESET_PB   = pb_q;
  assign LINK_UP    = up_q;
  assign LINK_FAIL  = fail_q;
  assign RETRY_CNT  = rcnt_q;
  assign LINK_DROPS = drops_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_k7_aurora_link_ctrl.sv
// Bench for k7_aurora_link_ctrl: each driven scenario queues the state
// transitions it should cause (state, outputs, counters, edge number);
// a negedge monitor pops and compares one entry per observed transition.
module tb_k7_aurora_link_ctrl;

  localparam int PMA = 4, PB = 3, TO = 20, DF = 4, MR = 2;
  localparam logic [2:0] S_WL = 3'd0, S_PMA = 3'd1, S_PB = 3'd2,
                         S_WU = 3'd3, S_UP = 3'd4, S_FAIL = 3'd5;

  logic       clk = 1'b0, rst = 1'b1, lock = 1'b0, ch = 1'b0, herr = 1'b0, rreq = 1'b0;
  logic       pma_init, reset_pb, link_up, link_fail;
  logic [7:0] retry_cnt, link_drops;
  logic [2:0] state;

  k7_aurora_link_ctrl #(
    .PMA_CYCLES(PMA), .PB_CYCLES(PB), .UP_TIMEOUT(TO),
    .DOWN_FILTER(DF), .MAX_RETRY(MR)
  ) dut (
    .CLK50(clk), .RST(rst), .DCM_LOCKED(lock), .CHANNEL_UP(ch),
    .HARD_ERR(herr), .RETRY_REQ(rreq), .PMA_INIT(pma_init),
    .RESET_PB(reset_pb), .LINK_UP(link_up), .LINK_FAIL(link_fail),
    .RETRY_CNT(retry_cnt), .LINK_DROPS(link_drops), .STATE(state)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0, n_fail = 0;

  typedef struct {
    logic [2:0] st;
    logic [7:0] rc;
    logic [7:0] dr;
    int         edge_n;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {PMA_INIT, RESET_PB, LINK_UP, LINK_FAIL} expected in each state.
  function automatic logic [3:0] lvl(input logic [2:0] s);
    return {(s == S_WL || s == S_PMA || s == S_FAIL),
            (s == S_WL || s == S_PMA || s == S_PB || s == S_FAIL),
            (s == S_UP), (s == S_FAIL)};
  endfunction

  task automatic push(input logic [2:0] st, input int rc, input int dr, input int e);
    exp_t x;
    x.st = st; x.rc = 8'(rc); x.dr = 8'(dr); x.edge_n = e;
    sbq.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic       mon_en = 1'b0;
  logic [2:0] prev_q;

  // Every state change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && (state !== prev_q)) begin
      if (sbq.size() == 0) begin
        chk("spurious_transition", 32'(state), 32'(prev_q));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("state@%0d", e.edge_n), 32'(state), 32'(e.st));
        chk($sformatf("levels@%0d", e.edge_n),
            32'({pma_init, reset_pb, link_up, link_fail}), 32'(lvl(e.st)));
        chk($sformatf("retry@%0d", e.edge_n), 32'(retry_cnt), 32'(e.rc));
        chk($sformatf("drops@%0d", e.edge_n), 32'(link_drops), 32'(e.dr));
        chk($sformatf("edge_of_s%0d", e.st), 32'(cyc), 32'(e.edge_n));
      end
    end
    prev_q <= state;
  end

  initial begin
    int t, r, w;
    // Reset values
    step(2);
    chk("rst_state", 32'(state), 32'(S_WL));
    chk("rst_pma", 32'(pma_init), 32'd1);
    chk("rst_pb", 32'(reset_pb), 32'd1);
    chk("rst_up", 32'(link_up), 32'd0);
    chk("rst_fail", 32'(link_fail), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_drops", 32'(link_drops), 32'd0);
    step(1); rst = 1'b0;
    step(2);
    mon_en = 1'b1;
    step(5);

    // 1. Nominal bring-up
    lock = 1'b1; t = cyc;
    push(S_PMA, 0, 0, t + 1); push(S_PB, 0, 0, t + 5); push(S_WU, 0, 0, t + 8);
    step(15); ch = 1'b1; push(S_UP, 0, 0, cyc + 3);
    step(6);
    chk("t1_link_up", 32'(link_up), 32'd1);
    chk("t1_retry", 32'(retry_cnt), 32'd0);

    // 3. Down filter: 3-cycle drop is absorbed, 5-cycle drop recovers
    ch = 1'b0; step(3); ch = 1'b1; step(6);
    chk("t3_short_drop", 32'(link_up), 32'd1);
    ch = 1'b0; t = cyc;
    push(S_PMA, 1, 1, t + 6); push(S_PB, 1, 1, t + 10); push(S_WU, 1, 1, t + 13);
    step(5); ch = 1'b1; push(S_UP, 0, 1, t + 14);
    step(12);

    // 4. Hard error pulse
    herr = 1'b1; t = cyc; step(1); herr = 1'b0;
    push(S_PMA, 1, 2, t + 3); push(S_PB, 1, 2, t + 7);
    push(S_WU, 1, 2, t + 10); push(S_UP, 0, 2, t + 11);
    step(14);

    // 5. Lock loss during PB_RST keeps RETRY_CNT
    ch = 1'b0; t = cyc; r = t + 6;
    push(S_PMA, 1, 3, r); push(S_PB, 1, 3, r + 4);
    step(r + 5 - t);
    lock = 1'b0; push(S_WL, 1, 3, r + 6);
    step(3);
    chk("t5_retry_kept", 32'(retry_cnt), 32'd1);
    chk("t5_resets_high", 32'({pma_init, reset_pb}), 32'd3);
    lock = 1'b1; t = cyc;
    push(S_PMA, 1, 3, t + 1); push(S_PB, 1, 3, t + 5); push(S_WU, 1, 3, t + 8);
    w = t + 8;

    // 6a. up_s rises exactly on the timeout cycle -> UP, no retry
    step(w + 17 - cyc); ch = 1'b1; push(S_UP, 0, 3, w + 20);
    step(6);

    // 6b. RETRY_REQ together with lock loss -> WAIT_LOCK
    rreq = 1'b1; lock = 1'b0; t = cyc; push(S_WL, 0, 3, t + 1);
    step(1); rreq = 1'b0; step(1);
    lock = 1'b1; t = cyc;
    push(S_PMA, 0, 3, t + 1); push(S_PB, 0, 3, t + 5);
    push(S_WU, 0, 3, t + 8); push(S_UP, 0, 3, t + 9);
    step(12);

    // 2. Timeouts exhaust retries -> FAIL, then manual relink
    ch = 1'b0; rreq = 1'b1; t = cyc; step(1); rreq = 1'b0;
    r = t + 1; push(S_PMA, 0, 3, r);
    for (int k = 0; k < 3; k++) begin
      push(S_PB, k, 3, r + 27 * k + 4);
      push(S_WU, k, 3, r + 27 * k + 7);
      if (k < 2) push(S_PMA, k + 1, 3, r + 27 * k + 27);
      else       push(S_FAIL, 2, 3, r + 27 * k + 27);
    end
    step(r + 84 - cyc);
    chk("t2_link_fail", 32'(link_fail), 32'd1);
    chk("t2_state", 32'(state), 32'(S_FAIL));
    step(5);
    rreq = 1'b1; t = cyc; step(1); rreq = 1'b0;
    push(S_PMA, 0, 3, t + 1); push(S_PB, 0, 3, t + 5); push(S_WU, 0, 3, t + 8);
    step(9); ch = 1'b1; push(S_UP, 0, 3, cyc + 3);
    step(11);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
